uart_rx_fifo_cfg: RTL

Parametrised UART receiver, successor to the fixed 8N1 receiver. Runtime-configurable frame format: 5-8 data bits, parity none/even/odd, 1 or 2 stop bits. Per-character parity and framing error detection, false-start rejection, and a DEPTH-entry receive FIFO with overrun reporting. Sits between the serial pad and the bus-side UART register block.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_sync_fifo.sv | 49 ++++
 rtl/uart_rx_fifo_cfg.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: frame-format encodings, rx FSM states
// and the packed receive-FIFO entry.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    localparam logic [1:0] DB_5 = 2'd0;
    localparam logic [1:0] DB_6 = 2'd1;
    localparam logic [1:0] DB_7 = 2'd2;
    localparam logic [1:0] DB_8 = 2'd3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    typedef struct packed {
        logic       frame_err;
        logic       parity_err;
        logic [7:0] data;
    } rx_entry_t;

    // Index of the last data bit for a data-bits code (5 bits -> index 4).
    function automatic logic [2:0] last_bit_idx(input logic [1:0] data_bits);
        return 3'd4 + {1'b0, data_bits};
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with one-extra-bit pointers and an occupancy output.
// Head entry is read combinationally from storage; a push into a full FIFO is only taken alongside a pop.
module uart_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign level   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            mem    <= '{default: '0};
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo_cfg.sv
// Runtime-configurable UART receiver (5-8 data bits, none/even/odd parity, 1-2 stop bits)
// feeding a DEPTH-entry receive FIFO with sticky overrun.
module uart_rx_fifo_cfg
    import uart_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   uart_clk,
    input  logic                   uart_rst_n,
    input  logic [15:0]            uart_divider,
    input  logic [1:0]             uart_data_bits,
    input  logic [1:0]             uart_parity,
    input  logic                   uart_stop2,
    input  logic                   uart_ser_rx,
    input  logic                   uart_rx_ready,
    output logic                   uart_rx_valid,
    output logic [7:0]             uart_rx_data,
    output logic                   uart_rx_parity_err,
    output logic                   uart_rx_frame_err,
    output logic [$clog2(DEPTH):0] uart_rx_level,
    output logic                   uart_rx_overrun,
    input  logic                   uart_overrun_clr,
    output logic                   uart_rx_busy
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_cur;
    logic                   rx_prev;

    rx_state_e   state, state_d;
    logic [15:0] cnt, cnt_d;
    logic [2:0]  bitcnt, bitcnt_d;
    logic [7:0]  shreg, shreg_d;
    logic [15:0] div_l, div_l_d;
    logic [1:0]  db_l, db_l_d;
    logic [1:0]  par_l, par_l_d;
    logic        stop2_l, stop2_l_d;
    logic        stop_idx, stop_idx_d;
    logic        par_err, par_err_d;
    logic        frm_err, frm_err_d;
    logic        par_en;
    logic        par_x;
    logic        push;
    rx_entry_t   push_entry;

    rx_entry_t   head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;

    assign rx_cur = sync_q[SYNC_STAGES-1];

    always_ff @(posedge uart_clk or negedge uart_rst_n) begin
        if (!uart_rst_n) begin
            sync_q  <= '1;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], uart_ser_rx};
            rx_prev <= rx_cur;
        end
    end

    assign par_en = (par_l == PAR_EVEN) || (par_l == PAR_ODD);
    assign par_x  = (^shreg) ^ rx_cur;

    always_comb begin
        state_d    = state;
        cnt_d      = cnt + 16'd1;
        bitcnt_d   = bitcnt;
        shreg_d    = shreg;
        div_l_d    = div_l;
        db_l_d     = db_l;
        par_l_d    = par_l;
        stop2_l_d  = stop2_l;
        stop_idx_d = stop_idx;
        par_err_d  = par_err;
        frm_err_d  = frm_err;
        push       = 1'b0;
        push_entry = '{frame_err: frm_err | ~rx_cur, parity_err: par_err, data: shreg};
        case (state)
            IDLE: begin
                cnt_d = '0;
                // Frame format is frozen here so mid-frame config writes cannot corrupt it.
                if (rx_prev && !rx_cur) begin
                    state_d    = START;
                    div_l_d    = uart_divider;
                    db_l_d     = uart_data_bits;
                    par_l_d    = uart_parity;
                    stop2_l_d  = uart_stop2;
                    bitcnt_d   = '0;
                    shreg_d    = '0;
                    stop_idx_d = 1'b0;
                    par_err_d  = 1'b0;
                    frm_err_d  = 1'b0;
                end
            end
            START: begin
                if (cnt == {1'b0, div_l[15:1]}) begin
                    cnt_d   = '0;
                    state_d = rx_cur ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == div_l) begin
                    cnt_d           = '0;
                    shreg_d[bitcnt] = rx_cur;
                    if (bitcnt == last_bit_idx(db_l)) begin
                        state_d = par_en ? PARITY : STOP;
                    end else begin
                        bitcnt_d = bitcnt + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (cnt == div_l) begin
                    cnt_d     = '0;
                    par_err_d = (par_l == PAR_ODD) ? ~par_x : par_x;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (cnt == div_l) begin
                    cnt_d     = '0;
                    frm_err_d = frm_err | ~rx_cur;
                    if (stop2_l && !stop_idx) begin
                        stop_idx_d = 1'b1;
                    end else begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge uart_clk or negedge uart_rst_n) begin
        if (!uart_rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            bitcnt   <= '0;
            shreg    <= '0;
            div_l    <= '0;
            db_l     <= DB_8;
            par_l    <= PAR_NONE;
            stop2_l  <= 1'b0;
            stop_idx <= 1'b0;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            bitcnt   <= bitcnt_d;
            shreg    <= shreg_d;
            div_l    <= div_l_d;
            db_l     <= db_l_d;
            par_l    <= par_l_d;
            stop2_l  <= stop2_l_d;
            stop_idx <= stop_idx_d;
            par_err  <= par_err_d;
            frm_err  <= frm_err_d;
        end
    end

    assign pop = uart_rx_valid && uart_rx_ready;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(rx_entry_t))
    ) u_fifo (
        .clk     (uart_clk),
        .rst_n   (uart_rst_n),
        .push    (push),
        .wr_data (push_entry),
        .pop     (pop),
        .rd_data (head),
        .level   (uart_rx_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // A drop on a full FIFO wins over a same-cycle clear so no overrun is lost.
    always_ff @(posedge uart_clk or negedge uart_rst_n) begin
        if (!uart_rst_n) begin
            uart_rx_overrun <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            uart_rx_overrun <= 1'b1;
        end else if (uart_overrun_clr) begin
            uart_rx_overrun <= 1'b0;
        end
    end

    assign uart_rx_valid      = !fifo_empty;
    assign uart_rx_data       = head.data;
    assign uart_rx_parity_err = head.parity_err;
    assign uart_rx_frame_err  = head.frame_err;
    assign uart_rx_busy       = (state != IDLE);

endmodule
